regfile_1w2r: RTL

//  Parametrised register file: one write port, two read ports, on a single clock.

---
 rtl/rf_pkg.sv | 11 +
 rtl/regfile_1w2r_dec.sv | 18 +
 rtl/regfile_1w2r.sv | 69 ++++++
 3 files changed

// File: rtl/rf_pkg.sv
// rf_pkg: shared register-file defaults and the one-hot helper used by the write decoder
package rf_pkg;
    localparam int RF_ADDR_W     = 5;
    localparam int RF_DATA_W     = 32;
    localparam int RF_MAX_ADDR_W = 10;
    localparam int RF_MAX_NREG   = 2 ** RF_MAX_ADDR_W;

    function automatic logic [RF_MAX_NREG-1:0] onehot(input logic [RF_MAX_ADDR_W-1:0] addr);
        return RF_MAX_NREG'(1) << addr;
    endfunction
endpackage

// File: rtl/regfile_1w2r_dec.sv
// onehot_dec: write-address decoder, exactly one bit set when enabled, all zero otherwise
module onehot_dec
    import rf_pkg::*;
#(
    parameter int ADDR_W = RF_ADDR_W
) (
    input  logic [ADDR_W-1:0]    i_addr,
    input  logic                 i_en,
    output logic [2**ADDR_W-1:0] o_sel
);
    localparam int NREG = 2 ** ADDR_W;

    if (ADDR_W > RF_MAX_ADDR_W) begin : g_bad_width
        $error("onehot_dec: ADDR_W exceeds RF_MAX_ADDR_W");
    end

    assign o_sel = i_en ? NREG'(onehot(RF_MAX_ADDR_W'(i_addr))) : '0;
endmodule

// File: rtl/regfile_1w2r.sv
// regfile_1w2r: 1-write/2-read register file with optional zero register, bypass and write strobe
module regfile_1w2r
    import rf_pkg::*;
#(
    parameter int ADDR_W  = RF_ADDR_W,
    parameter int DATA_W  = RF_DATA_W,
    parameter bit ZERO_R0 = 1'b1,
    parameter bit BYPASS  = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_we,
    input  logic [ADDR_W-1:0]    i_waddr,
    input  logic [DATA_W-1:0]    i_wdata,
    input  logic [ADDR_W-1:0]    i_raddr_a,
    input  logic [ADDR_W-1:0]    i_raddr_b,
    output logic [DATA_W-1:0]    o_rdata_a,
    output logic [DATA_W-1:0]    o_rdata_b,
    output logic [2**ADDR_W-1:0] o_wsel_q
);
    localparam int NREG = 2 ** ADDR_W;

    logic [NREG-1:0]   w_wsel;
    logic [DATA_W-1:0] r_regs [NREG];
    logic              w_fwd_a;
    logic              w_fwd_b;

    onehot_dec #(.ADDR_W(ADDR_W)) u_dec (
        .i_addr (i_waddr),
        .i_en   (i_we),
        .o_sel  (w_wsel)
    );

    for (genvar i = 0; i < NREG; i++) begin : g_reg
        if (ZERO_R0 && i == 0) begin : g_zero
            assign r_regs[i] = '0;
        end else begin : g_flop
            // Storage flop, loaded only when the decoder selects this register
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    r_regs[i] <= '0;
                else if (w_wsel[i])
                    r_regs[i] <= i_wdata;
            end
        end
    end

    // Strobe records the requested write, even when the zero register discards it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            o_wsel_q <= '0;
        else
            o_wsel_q <= w_wsel;
    end

    // Forwarding is suppressed in reset so reads return 0 while rst_n is low
    assign w_fwd_a = BYPASS && rst_n && i_we && (i_raddr_a == i_waddr);
    assign w_fwd_b = BYPASS && rst_n && i_we && (i_raddr_b == i_waddr);

    // Port A read: zero register wins, then bypass, then stored value
    always_comb begin
        o_rdata_a = (ZERO_R0 && i_raddr_a == '0) ? '0 : w_fwd_a ? i_wdata : r_regs[i_raddr_a];
    end

    // Port B read: same priority as port A, resolved independently
    always_comb begin
        o_rdata_b = (ZERO_R0 && i_raddr_b == '0) ? '0 : w_fwd_b ? i_wdata : r_regs[i_raddr_b];
    end
endmodule
